// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Instruction prefetch queue sitting between program memory and IF/ID.
//   Keeps at most one fetch request outstanding and buffers up to DEPTH
//   fetched words. A redirect from EX flushes the queue. A request that is
//   still in flight when the redirect arrives is retired in DISCARD, and its
//   data is dropped.
//
// Ports
//   clk            : clock, all state updates on rising edge
//   reset          : asynchronous active-low reset
//   mem_req_o      : fetch request to program memory
//   mem_addr_o     : word-aligned fetch address
//   mem_ack_i      : request accepted, mem_rdata_i valid this cycle
//   mem_rdata_i    : fetched instruction word
//   redirect_i     : flush and refetch from redirect_pc_i
//   redirect_pc_i  : redirect target
//   inst_valid_o   : head entry valid
//   inst_o         : head instruction
//   inst_pc_o      : PC of head instruction
//   inst_ready_i   : IF/ID accepts head
//   count_o        : number of valid entries
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_rdata_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       inst_valid_o,
  output logic [31:0]                inst_o,
  output logic [31:0]                inst_pc_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_stale_pc;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_inst_q [DEPTH];
  logic [31:0]     r_pc_q   [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_slot_free;
  logic [CW-1:0]   w_count_n;

  // A request is outstanding in FETCH and DISCARD. Gating with reset keeps
  // the request low while reset is held, even though the state already
  // sits in FETCH.
  assign mem_req_o  = reset & (r_state != S_WAIT);
  // DISCARD must keep presenting the abandoned address until it is acked,
  // while r_fetch_pc already holds the redirect target.
  assign mem_addr_o = (r_state == S_DISCARD) ? r_stale_pc : r_fetch_pc;

  assign inst_valid_o = (r_count != '0);
  assign inst_o       = inst_valid_o ? r_inst_q[r_head] : '0;
  assign inst_pc_o    = inst_valid_o ? r_pc_q[r_head]   : '0;
  assign count_o      = r_count;

  assign w_push      = (r_state == S_FETCH) & mem_ack_i & ~redirect_i;
  assign w_pop       = inst_valid_o & inst_ready_i & ~redirect_i;
  assign w_count_n   = redirect_i ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  // No request is outstanding once an ack lands, so the next issue only
  // needs room for one more entry after this cycle's push/pop.
  assign w_slot_free = (w_count_n < CW'(DEPTH));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (redirect_i)     w_next_state = mem_ack_i ? S_FETCH : S_DISCARD;
        else if (mem_ack_i) w_next_state = w_slot_free ? S_FETCH : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_i || w_slot_free) w_next_state = S_FETCH;
      end
      S_DISCARD: begin
        if (mem_ack_i) w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_stale_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_inst_q[i] <= '0;
        r_pc_q[i]   <= '0;
      end
    end else begin
      r_state <= w_next_state;
      r_count <= w_count_n;
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        r_head     <= '0;
        r_tail     <= '0;
        if (r_state == S_FETCH && !mem_ack_i) r_stale_pc <= r_fetch_pc;
      end else begin
        if (w_push) begin
          r_inst_q[r_tail] <= mem_rdata_i;
          r_pc_q[r_tail]   <= r_fetch_pc;
          r_tail           <= r_tail + AW'(1);
          r_fetch_pc       <= r_fetch_pc + 32'd4;
        end
        if (w_pop) r_head <= r_head + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  localparam logic [31:0] K = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic [2:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Program memory model: word at address A reads as A ^ K.
  assign mem_rdata_i = mem_addr_o ^ K;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0040_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .count_o       (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack, input logic rdy);
    reset = 1'b0;
    mem_ack_i = ack;
    inst_ready_i = rdy;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    mem_ack_i = 1'b0;
    inst_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    #12;
    // Reset values while reset is held
    chk("rst_req",   {31'b0, mem_req_o},    32'd0);
    chk("rst_cnt",   {29'b0, count_o},      32'd0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst",  inst_o,                32'd0);
    chk("rst_pc",    inst_pc_o,             32'd0);

    // Streaming: ack tied 1, ready 1
    do_reset(1'b1, 1'b1);
    chk("s_req0",   {31'b0, mem_req_o},    32'd1);
    chk("s_addr0",  mem_addr_o,            32'h0040_0000);
    chk("s_valid0", {31'b0, inst_valid_o}, 32'd0);
    tick();
    chk("s_valid1", {31'b0, inst_valid_o}, 32'd1);
    chk("s_pc1",    inst_pc_o,             32'h0040_0000);
    chk("s_inst1",  inst_o,                32'h0040_0000 ^ K);
    chk("s_addr1",  mem_addr_o,            32'h0040_0004);
    tick();
    chk("s_pc2",    inst_pc_o,             32'h0040_0004);
    chk("s_cnt2",   {29'b0, count_o},      32'd1);
    chk("s_addr2",  mem_addr_o,            32'h0040_0008);
    tick();
    chk("s_pc3",    inst_pc_o,             32'h0040_0008);

    // Fill: ready low until the queue is full
    do_reset(1'b1, 1'b0);
    tick(); tick(); tick();
    chk("f_cnt3",   {29'b0, count_o},      32'd3);
    chk("f_req3",   {31'b0, mem_req_o},    32'd1);
    tick();
    chk("f_cnt4",   {29'b0, count_o},      32'd4);
    chk("f_req4",   {31'b0, mem_req_o},    32'd0);
    chk("f_pc4",    inst_pc_o,             32'h0040_0000);
    tick();
    chk("f_hold_c", {29'b0, count_o},      32'd4);
    chk("f_hold_p", inst_pc_o,             32'h0040_0000);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    chk("f_pop_c",  {29'b0, count_o},      32'd3);
    chk("f_pop_p",  inst_pc_o,             32'h0040_0004);
    chk("f_req5",   {31'b0, mem_req_o},    32'd1);
    chk("f_addr5",  mem_addr_o,            32'h0040_0010);
    tick();
    chk("f_cnt6",   {29'b0, count_o},      32'd4);
    chk("f_req6",   {31'b0, mem_req_o},    32'd0);

    // Delayed ack: request held stable
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_req",  {31'b0, mem_req_o},    32'd1);
      chk("d_addr", mem_addr_o,            32'h0040_0000);
      chk("d_cnt",  {29'b0, count_o},      32'd0);
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("d_cnt1",   {29'b0, count_o},      32'd1);
    chk("d_pc1",    inst_pc_o,             32'h0040_0000);
    chk("d_addr1",  mem_addr_o,            32'h0040_0004);
    tick();
    chk("d_cnt1b",  {29'b0, count_o},      32'd1);

    // Redirect with request outstanding, unacked -> DISCARD
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0103;
    tick();
    redirect_i = 1'b0;
    chk("r_cnt",    {29'b0, count_o},      32'd0);
    chk("r_valid",  {31'b0, inst_valid_o}, 32'd0);
    chk("r_req",    {31'b0, mem_req_o},    32'd1);
    chk("r_addr",   mem_addr_o,            32'h0040_0004);
    mem_ack_i = 1'b1;
    inst_ready_i = 1'b1;
    tick();
    chk("r_drop_c", {29'b0, count_o},      32'd0);
    chk("r_addr2",  mem_addr_o,            32'h0040_0100);
    tick();
    chk("r_pc",     inst_pc_o,             32'h0040_0100);
    chk("r_addr3",  mem_addr_o,            32'h0040_0104);

    // Redirect again while in DISCARD -> newest target wins
    mem_ack_i = 1'b0;
    inst_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0300;
    tick();
    chk("dd_addr1", mem_addr_o,            32'h0040_0104);
    chk("dd_cnt",   {29'b0, count_o},      32'd0);
    redirect_pc_i = 32'h0040_0400;
    tick();
    redirect_i = 1'b0;
    chk("dd_addr2", mem_addr_o,            32'h0040_0104);
    chk("dd_req",   {31'b0, mem_req_o},    32'd1);
    mem_ack_i = 1'b1;
    inst_ready_i = 1'b1;
    tick();
    chk("dd_addr3", mem_addr_o,            32'h0040_0400);
    chk("dd_valid", {31'b0, inst_valid_o}, 32'd0);
    tick();
    chk("dd_pc",    inst_pc_o,             32'h0040_0400);

    // Redirect + ack + pop in same cycle with two entries
    inst_ready_i = 1'b0;
    tick();
    chk("x_cnt2",   {29'b0, count_o},      32'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0800;
    inst_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    chk("x_cnt0",   {29'b0, count_o},      32'd0);
    chk("x_valid",  {31'b0, inst_valid_o}, 32'd0);
    chk("x_addr",   mem_addr_o,            32'h0040_0800);
    tick();
    chk("x_pc",     inst_pc_o,             32'h0040_0800);
    chk("x_inst",   inst_o,                32'h0040_0800 ^ K);
    chk("x_cnt1",   {29'b0, count_o},      32'd1);

    // Address wrap at top of memory
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("w_addr0",  mem_addr_o,            32'hFFFF_FFFC);
    tick();
    chk("w_addr1",  mem_addr_o,            32'h0000_0000);
    chk("w_pc1",    inst_pc_o,             32'hFFFF_FFFC);
    tick();
    chk("w_pc2",    inst_pc_o,             32'h0000_0000);

    // Reset mid-request abandons it
    mem_ack_i = 1'b0;
    inst_ready_i = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("m_req",    {31'b0, mem_req_o},    32'd0);
    chk("m_cnt",    {29'b0, count_o},      32'd0);
    chk("m_inst",   inst_o,                32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("m_addr",   mem_addr_o,            32'h0040_0000);
    mem_ack_i = 1'b1;
    tick();
    chk("m_cnt1",   {29'b0, count_o},      32'd1);
    chk("m_pc1",    inst_pc_o,             32'h0040_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
